// File: rtl/traffic_pkg.sv
// Shared types and helpers for the two-way intersection controller.
//   state_e : six-phase signal sequence (3-bit encoding, 6 and 7 unused)
//   RED/YELLOW/GREEN : one-hot lamp codes {red, yellow, green}
//   lamps() : maps a state to the {light_A, light_B} lamp pair
package traffic_pkg;

   typedef enum logic [2:0] {
      A_GREEN  = 3'd0,
      A_YELLOW = 3'd1,
      CLR_AB   = 3'd2,
      B_GREEN  = 3'd3,
      B_YELLOW = 3'd4,
      CLR_BA   = 3'd5
   } state_e;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   // Unused encodings show red on both approaches for the single cycle
   // before the FSM recovers, so the safety invariant still holds.
   function automatic logic [5:0] lamps(input state_e s);
      logic [5:0] l;
      case (s)
         A_GREEN:  l = {GREEN,  RED};
         A_YELLOW: l = {YELLOW, RED};
         CLR_AB:   l = {RED,    RED};
         B_GREEN:  l = {RED,    GREEN};
         B_YELLOW: l = {RED,    YELLOW};
         CLR_BA:   l = {RED,    RED};
         default:  l = {RED,    RED};
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Dwell counter for one signal phase.
//   clk   : system clock, rising edge
//   reset : synchronous active-high clear
//   load  : state change this cycle; restarts the count for the next phase
//   limit : current phase length in cycles (>= 1)
//   done  : high in the last cycle of the phase (cnt == limit - 1)
module traffic_phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] limit,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset || load) cnt_q <= '0;
      else               cnt_q <= cnt_q + CNT_W'(1);
   end

   assign done = (cnt_q == limit - CNT_W'(1));

endmodule

// File: rtl/traffic_controller.sv
// Two-way intersection signal controller (Moore FSM).
//   light_A : approach A lamps, one-hot {red, yellow, green}
//   light_B : approach B lamps, same encoding
//   clk     : system clock (1 Hz, one cycle per second)
//   reset   : synchronous active-high; forces A_GREEN with a fresh count
module traffic_controller
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_TIME   = 5,
   parameter int unsigned YELLOW_TIME  = 1,
   parameter int unsigned ALL_RED_TIME = 1,
   parameter int unsigned CNT_W        = 8
) (
   output logic [2:0] light_A,
   output logic [2:0] light_B,
   input  logic       clk,
   input  logic       reset
);

   localparam logic [CNT_W-1:0] T_GRN = CNT_W'(GREEN_TIME);
   localparam logic [CNT_W-1:0] T_YEL = CNT_W'(YELLOW_TIME);
   localparam logic [CNT_W-1:0] T_CLR = CNT_W'(ALL_RED_TIME);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] limit;
   logic             done, illegal, adv;

   always_comb begin
      state_d = A_GREEN;
      limit   = T_GRN;
      illegal = 1'b0;
      case (state_q)
         A_GREEN:  begin limit = T_GRN; state_d = A_YELLOW; end
         A_YELLOW: begin limit = T_YEL; state_d = CLR_AB;   end
         CLR_AB:   begin limit = T_CLR; state_d = B_GREEN;  end
         B_GREEN:  begin limit = T_GRN; state_d = B_YELLOW; end
         B_YELLOW: begin limit = T_YEL; state_d = CLR_BA;   end
         CLR_BA:   begin limit = T_CLR; state_d = A_GREEN;  end
         default:  illegal = 1'b1;
      endcase
   end

   // An unused encoding advances immediately to A_GREEN and clears the
   // counter, exactly like a normal phase change.
   assign adv = done | illegal;

   always_ff @(posedge clk) begin
      if (reset)    state_q <= A_GREEN;
      else if (adv) state_q <= state_d;
   end

   traffic_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (adv),
      .limit (limit),
      .done  (done)
   );

   assign {light_A, light_B} = lamps(state_q);

endmodule

// File: tb/tb_traffic_controller.sv
module tb_traffic_controller;

   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

   logic       clk = 1'b0;
   logic       reset, reset2;
   logic [2:0] a1, b1, a2, b2;
   int         t1, t2;
   int         n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   traffic_controller dut1 (
      .light_A (a1), .light_B (b1), .clk (clk), .reset (reset)
   );

   traffic_controller #(.GREEN_TIME(2), .YELLOW_TIME(3), .ALL_RED_TIME(2), .CNT_W(8)) dut2 (
      .light_A (a2), .light_B (b2), .clk (clk), .reset (reset2)
   );

   // Expected {A,B} for t cycles after the last reset edge.
   function automatic logic [5:0] model(input int t, input int g, input int y, input int r);
      int p, k;
      p = 2 * (g + y + r);
      k = t % p;
      if      (k < g)             return {G, R};
      else if (k < g + y)         return {Y, R};
      else if (k < g + y + r)     return {R, R};
      else if (k < 2*g + y + r)   return {R, G};
      else if (k < 2*g + 2*y + r) return {R, Y};
      else                        return {R, R};
   endfunction

   task automatic cmp(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Safety: each output one-hot and never both approaches off red.
   function automatic logic [5:0] safety(input logic [2:0] a, input logic [2:0] b);
      return {3'b000, $onehot(a), $onehot(b), (a != R) && (b != R)};
   endfunction

   task automatic tick(input string tag);
      logic r1, r2;
      r1 = reset;
      r2 = reset2;
      @(posedge clk);
      #1;
      t1 = r1 ? 0 : t1 + 1;
      t2 = r2 ? 0 : t2 + 1;
      cmp({tag, "_dflt"},  {a1, b1}, model(t1, 5, 1, 1));
      cmp({tag, "_ovr"},   {a2, b2}, model(t2, 2, 3, 2));
      cmp({tag, "_safe1"}, safety(a1, b1), 6'b000_110);
      cmp({tag, "_safe2"}, safety(a2, b2), 6'b000_110);
   endtask

   initial begin
      t1 = 0;
      t2 = 0;
      reset  = 1'b1;
      reset2 = 1'b1;
      tick("rst");
      tick("rst");
      cmp("rst_state", {a1, b1}, {G, R});
      reset  = 1'b0;
      reset2 = 1'b0;

      // Two full default periods from release, wrapping at 14.
      repeat (28) tick("run");
      cmp("wrap_14", {a1, b1}, {G, R});

      // Long reset: held in A_GREEN, count restarts after release.
      reset = 1'b1;
      repeat (10) tick("long_rst");
      reset = 1'b0;
      repeat (14) tick("after_long");

      // Reset during A_YELLOW aborts straight to green.
      repeat (5) tick("to_yel");
      cmp("pre_mid", {a1, b1}, {Y, R});
      reset = 1'b1;
      tick("mid_rst");
      cmp("mid_rst", {a1, b1}, {G, R});
      reset = 1'b0;
      repeat (14) tick("after_mid");

      // Reset during B_GREEN: no B yellow phase.
      repeat (9) tick("to_bgrn");
      cmp("pre_bgrn", {a1, b1}, {R, G});
      reset = 1'b1;
      tick("bgrn_rst");
      cmp("bgrn_rst", {a1, b1}, {G, R});
      reset = 1'b0;

      // Soak: sequence, period and safety every cycle.
      repeat (100) tick("soak");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/traffic_controller.md
Name: traffic_controller

Overview:
Two-way intersection signal controller for approach A and approach B. A Moore FSM sequences the lights through green, yellow and all-red clearance phases. Each phase lasts a fixed, parameterised number of clock cycles. The system clock is 1 Hz, so 1 cycle = 1 s, and the block drives the lamp outputs directly.

Parameters:
- GREEN_TIME, 5: cycles each approach holds green; must be >= 1.
- YELLOW_TIME, 1: cycles each approach holds yellow; must be >= 1.
- ALL_RED_TIME, 1: cycles both approaches are red between handovers; must be >= 1.
- CNT_W, 8: dwell-counter width; must hold max(time) - 1.

Ports:
- clk, input, 1: system clock; rising edge active.
- reset, input, 1: synchronous, active-high reset.
- light_A, output, 3: approach A lamps, one-hot {red, yellow, green} = bits [2:0].
- light_B, output, 3: approach B lamps, same encoding.
- Positional port order is light_A, light_B, clk, reset.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Lamp encoding:
  - RED = 3'b100, YELLOW = 3'b010, GREEN = 3'b001.
  - Exactly one bit is set per output at all times after the first reset.
- States, with light_A / light_B:
  - A_GREEN: GREEN / RED.
  - A_YELLOW: YELLOW / RED.
  - CLR_AB: RED / RED.
  - B_GREEN: RED / GREEN.
  - B_YELLOW: RED / YELLOW.
  - CLR_BA: RED / RED.
- Sequence: A_GREEN -> A_YELLOW -> CLR_AB -> B_GREEN -> B_YELLOW -> CLR_BA -> A_GREEN, wrapping forever.
- Dwell counter:
  - Cleared on every state entry.
  - Increments each cycle.
  - When cnt == phase_time - 1, the next edge advances the state and clears cnt.
  - Each state therefore lasts exactly phase_time cycles.
  - Full cycle with defaults = 5+1+1+5+1+1 = 14 cycles.
- Outputs are decoded combinationally from the registered state (Moore), so they change only just after a clk rising edge. No dependency on reset within a cycle.
- Reset:
  - A rising edge with reset = 1 forces state = A_GREEN and cnt = 0.
  - Outputs become light_A = 3'b001, light_B = 3'b100 after that edge.
  - While reset is held high, the block stays in A_GREEN with cnt = 0, with no advancement.
  - After reset deasserts, the first A_GREEN lasts GREEN_TIME cycles counted from the last reset edge.
- Reset mid-operation: any state or count is aborted at the reset edge, with no intermediate yellow phase. An abrupt return to A_GREEN is the required behaviour.
- Before the first reset edge, state and outputs are unspecified (X in simulation). No initial blocks are used, so benches must reset first.
- Safety invariant: light_A and light_B are never both non-RED in the same cycle.
- Illegal or unused state encodings recover to A_GREEN on the next edge, with cnt cleared.

Decomposition:
- Package traffic_pkg contains:
  - The state enum (6 states, 3-bit).
  - Lamp constants RED, YELLOW and GREEN.
  - A function mapping state to the {light_A, light_B} pair.
- One sub-module, traffic_phase_timer:
  - Inputs: clk, reset, load (state change), limit.
  - Output: done (cnt == limit - 1).
  - Holds the CNT_W-bit counter.
- The top module holds the state register and next-state/output decode.

Test Plan:
- Reset then run: assert reset for 1 cycle, release.
  - A=001/B=100 for 5 cycles, A=010 for 1, both 100 for 1, B=001 for 5, B=010 for 1, both 100 for 1.
  - Then back to A=001 at cycle 14.
- Long reset: hold reset high for 10 cycles. Outputs stay A=001/B=100 throughout, and the count restarts only after release.
- Mid-cycle reset: run 6 cycles (A_YELLOW), pulse reset for 1 cycle. The next edge gives A=001/B=100, and the full 5-cycle green follows.
- Reset during B_GREEN: at cycle 9, pulse reset. The response is A=001/B=100 immediately after the edge, with no B yellow.
- Safety and one-hot: run 100 cycles at defaults and check every cycle.
  - Each output is one-hot.
  - Never both outputs != 100.
  - Period is exactly 14.
- Parameter override: GREEN_TIME=2, YELLOW_TIME=3, ALL_RED_TIME=2. Phase lengths are 2/3/2/2/3/2, period 14.
